// File: rtl/ysyx_24100005_lsu.sv
// ysyx_24100005_lsu: multi-cycle load/store unit between the execute stage and a valid/ready data bus.
// Optional WAIT-state timeout is enabled by defining YSYX_24100005_LSU_TIMEOUT_EN.
module ysyx_24100005_lsu #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  output logic                 rsp_valid,
  output logic [XLEN-1:0]      rsp_rdata,
  output logic                 rsp_err,
  output logic                 mem_valid,
  input  logic                 mem_ready,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  output logic [XLEN/8-1:0]    mem_wmask,
  input  logic                 mem_rvalid,
  input  logic [XLEN-1:0]      mem_rdata
);

  localparam int unsigned MASK_W = XLEN / 8;
  localparam int unsigned OFF_W  = $clog2(MASK_W);

  if (!(XLEN == 32 || XLEN == 64) || TIMEOUT_CYC == 0) begin : g_param_check
    $error("ysyx_24100005_lsu: XLEN must be 32 or 64 and TIMEOUT_CYC nonzero");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic                err_q, err_d;

`ifdef YSYX_24100005_LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  // Request legality is judged on the live request so a bad access never reaches the bus.
  logic req_bad;
  always_comb begin
    case (req_funct3[1:0])
      2'd0:    req_bad = 1'b0;
      2'd1:    req_bad = req_addr[0];
      2'd2:    req_bad = |req_addr[1:0];
      default: req_bad = (MASK_W < 8) || (|req_addr[2:0]);
    endcase
  end

  logic [1:0]       size_q;
  logic [OFF_W-1:0] off_q;
  logic [OFF_W+2:0] shamt;
  assign size_q = funct3_q[1:0];
  assign off_q  = addr_q[OFF_W-1:0];
  assign shamt  = {off_q, 3'b000};

  logic [MASK_W-1:0] size_mask;
  logic [XLEN-1:0]   keep;
  logic              sign_bit;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   load_ext;

  assign shifted = mem_rdata >> shamt;

  always_comb begin
    case (size_q)
      2'd0: begin
        size_mask = MASK_W'(1);
        keep      = XLEN'(8'hFF);
        sign_bit  = shifted[7];
      end
      2'd1: begin
        size_mask = MASK_W'(3);
        keep      = XLEN'(16'hFFFF);
        sign_bit  = shifted[15];
      end
      2'd2: begin
        size_mask = MASK_W'(15);
        keep      = XLEN'(32'hFFFF_FFFF);
        sign_bit  = shifted[31];
      end
      default: begin
        size_mask = '1;
        keep      = '1;
        sign_bit  = 1'b0;
      end
    endcase
    // funct3[2] set selects the unsigned (zero-extending) load variants.
    load_ext = (shifted & keep) | ((!funct3_q[2] && sign_bit) ? ~keep : '0);
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
`ifdef YSYX_24100005_LSU_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          err_d    = req_bad;
          state_d  = req_bad ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          state_d = S_WAIT;
`ifdef YSYX_24100005_LSU_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = we_q ? '0 : load_ext;
          state_d = S_RESP;
        end
`ifdef YSYX_24100005_LSU_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the whole datapath is reset too, so outputs derived from it are defined straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef YSYX_24100005_LSU_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef YSYX_24100005_LSU_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid & err_q;

  assign mem_valid = (state_q == S_REQ);
  assign mem_we    = mem_valid & we_q;
  assign mem_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_wmask = mem_we ? (size_mask << off_q) : '0;
  assign mem_wdata = mem_we ? (wdata_q << shamt) : '0;

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Self-checking bench for ysyx_24100005_lsu (XLEN=32): table-driven accesses plus stall, reset and timeout sequences.
module tb_ysyx_24100005_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  ysyx_24100005_lsu #(
    .XLEN(32),
    .ADDR_W(32),
    .TIMEOUT_CYC(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_funct3(req_funct3),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_rdata;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] bus_rdata,
                              input logic [31:0] exp_maddr, input logic [3:0] exp_wmask,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                              input logic exp_err);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.bus_rdata = bus_rdata;
    v.exp_maddr = exp_maddr; v.exp_wmask = exp_wmask; v.exp_wdata = exp_wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {req_ready, rsp_valid, rsp_err, mem_valid, mem_we}, 5'b10000);
    check({tag, "_rdata"}, rsp_rdata, 32'h0);
    check({tag, "_wmask"}, mem_wmask, 4'h0);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    check($sformatf("v%0d_req_ready", i), req_ready, 1'b1);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    if (v.exp_err) begin
      check($sformatf("v%0d_early_err", i), {rsp_valid, rsp_err, mem_valid}, 3'b110);
      check($sformatf("v%0d_err_rdata", i), rsp_rdata, 32'h0);
    end else begin
      check($sformatf("v%0d_mem_valid_we", i), {mem_valid, mem_we, rsp_valid}, {1'b1, v.we, 1'b0});
      check($sformatf("v%0d_mem_addr", i), mem_addr, v.exp_maddr);
      check($sformatf("v%0d_wmask", i), mem_wmask, v.exp_wmask);
      if (v.we) check($sformatf("v%0d_wdata", i), mem_wdata, v.exp_wdata);
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      check($sformatf("v%0d_wait", i), {mem_valid, rsp_valid, req_ready}, 3'b000);
      mem_rvalid = 1'b1; mem_rdata = v.bus_rdata;
      @(negedge clk);
      mem_rvalid = 1'b0;
      check($sformatf("v%0d_rsp", i), {rsp_valid, rsp_err}, 2'b10);
      check($sformatf("v%0d_rdata", i), rsp_rdata, v.exp_rdata);
    end
    @(negedge clk);
    check($sformatf("v%0d_back_idle", i), {rsp_valid, req_ready, mem_valid}, 3'b010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(0, 3'b000, 32'h8000_0003, 32'h0,         32'h8011_2233, 32'h8000_0000, 4'h0, 32'h0,         32'hFFFF_FF80, 0); // LB
    vecs[1]  = mk(0, 3'b101, 32'h8000_0002, 32'h0,         32'hBEEF_1234, 32'h8000_0000, 4'h0, 32'h0,         32'h0000_BEEF, 0); // LHU
    vecs[2]  = mk(1, 3'b000, 32'h8000_0001, 32'h0000_00AB, 32'hDEAD_BEEF, 32'h8000_0000, 4'h2, 32'h0000_AB00, 32'h0,         0); // SB
    vecs[3]  = mk(0, 3'b010, 32'h8000_0002, 32'h0,         32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         1); // LW misaligned
    vecs[4]  = mk(0, 3'b001, 32'h8000_0006, 32'h0,         32'h8001_7FFF, 32'h8000_0004, 4'h0, 32'h0,         32'hFFFF_8001, 0); // LH
    vecs[5]  = mk(0, 3'b100, 32'h8000_0001, 32'h0,         32'h1234_F600, 32'h8000_0000, 4'h0, 32'h0,         32'h0000_00F6, 0); // LBU
    vecs[6]  = mk(0, 3'b010, 32'h8000_0004, 32'h0,         32'hCAFE_BABE, 32'h8000_0004, 4'h0, 32'h0,         32'hCAFE_BABE, 0); // LW
    vecs[7]  = mk(1, 3'b001, 32'h8000_000A, 32'h1234_5678, 32'h0,         32'h8000_0008, 4'hC, 32'h5678_0000, 32'h0,         0); // SH
    vecs[8]  = mk(1, 3'b010, 32'h8000_0010, 32'h1122_3344, 32'h0,         32'h8000_0010, 4'hF, 32'h1122_3344, 32'h0,         0); // SW
    vecs[9]  = mk(0, 3'b011, 32'h8000_0000, 32'h0,         32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         1); // LD illegal
    vecs[10] = mk(1, 3'b001, 32'h8000_0003, 32'h0000_BBCC, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         1); // SH misaligned
    vecs[11] = mk(0, 3'b000, 32'h8000_0000, 32'h0,         32'hFFFF_FF7F, 32'h8000_0000, 4'h0, 32'h0,         32'h0000_007F, 0); // LB positive
    vecs[12] = mk(0, 3'b101, 32'h8000_0000, 32'h0,         32'hFFFF_8000, 32'h8000_0000, 4'h0, 32'h0,         32'h0000_8000, 0); // LHU offset 0

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Stalled bus: request and bus outputs must hold while mem_ready stays low.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h8000_0020; req_wdata = 32'h55AA_55AA;
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h8000_0104; req_wdata = 32'h0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d_ctrl", k), {mem_valid, mem_we, req_ready}, 3'b110);
      check($sformatf("stall%0d_addr", k), mem_addr, 32'h8000_0020);
      check($sformatf("stall%0d_wdata", k), mem_wdata, 32'h55AA_55AA);
      check($sformatf("stall%0d_wmask", k), mem_wmask, 4'hF);
      mem_rvalid = (k == 2);
      @(negedge clk);
    end
    mem_rvalid = 1'b0; req_valid = 1'b0;
    check("stall_still_req", {mem_valid, rsp_valid}, 2'b10);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("stall_wait", {mem_valid, rsp_valid, req_ready}, 3'b000);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    check_reset_outputs("rst_held");
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("post_rst%0d", k), {rsp_valid, req_ready, mem_valid}, 3'b010);
    end
    run_vec(6);

`ifdef YSYX_24100005_LSU_TIMEOUT_EN
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0040;
    @(negedge clk);
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("to_wait%0d", k), {rsp_valid, req_ready}, 2'b00);
      @(negedge clk);
    end
    check("to_wait3", {rsp_valid, req_ready}, 2'b00);
    @(negedge clk);
    check("to_rsp", {rsp_valid, rsp_err}, 2'b11);
    check("to_rdata", rsp_rdata, 32'h0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("to_late%0d", k), {rsp_valid, req_ready, mem_valid}, 3'b010);
    end
    mem_rvalid = 1'b0;
`else
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0040;
    @(negedge clk);
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0)
        check($sformatf("long_wait%0d", k), {rsp_valid, req_ready}, 2'b00);
      @(negedge clk);
    end
    check("long_wait_end", {rsp_valid, req_ready}, 2'b00);
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("long_rsp", {rsp_valid, rsp_err}, 2'b10);
    check("long_rdata", rsp_rdata, 32'h0BAD_F00D);
`endif
    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
